st_align_unit: RTL

ST_ALIGN_UNIT -- requirements
Module: st_align_unit

---
 rtl/st_pkg.sv | 23 ++
 rtl/st_lane_shift.sv | 27 ++
 rtl/st_align_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/st_pkg.sv
// Shared types for the store alignment unit: store funct3 encodings, FSM states
// and the legality check for a store's size field.
package st_pkg;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010,
        F3_SD = 3'b011
    } st_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } st_state_e;

    // funct3[2] has no store meaning; sd only exists on a 64-bit datapath.
    function automatic logic size_illegal(input logic [2:0] f3, input int xlen);
        return f3[2] || ((xlen == 32) && (f3 == F3_SD));
    endfunction

endpackage

// File: rtl/st_lane_shift.sv
// Combinational lane placer: moves right-aligned store data and its byte mask
// up by the byte offset into a double-width window (lower half = LO beat).
module st_lane_shift #(
    parameter int XLEN  = 32,
    parameter int NB    = XLEN / 8,
    parameter int OFF_W = $clog2(NB)
) (
    input  logic [XLEN-1:0]   data,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size_log2,
    output logic [2*XLEN-1:0] data_sh,
    output logic [2*NB-1:0]   mask_sh
);

    logic [2*NB-1:0] base_mask;

    always_comb begin
        base_mask = '0;
        for (int i = 0; i < NB; i++) begin
            base_mask[i] = (i < (1 << size_log2));
        end
    end

    assign data_sh = {{XLEN{1'b0}}, data} << {off, 3'b000};
    assign mask_sh = base_mask << off;

endmodule

// File: rtl/st_align_unit.sv
// Store alignment unit: turns a right-aligned store into one or two word beats.
// Define ST_SPLIT_EN to split word-crossing stores into LO+HI beats; otherwise they are rejected.
module st_align_unit
    import st_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    output logic              done,
    output logic              err
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    st_state_e         state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]     mem_wmask_q, mem_wmask_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [2*XLEN-1:0] sh_data;
    logic [2*NB-1:0]   sh_mask;
    logic              accept, reject, crosses;
    logic [ADDR_W-1:0] addr_lo;

    st_lane_shift #(.XLEN(XLEN)) u_shift (
        .data      (req_data),
        .off       (req_addr[OFF_W-1:0]),
        .size_log2 (req_funct3[1:0]),
        .data_sh   (sh_data),
        .mask_sh   (sh_mask)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign crosses   = |sh_mask[2*NB-1:NB];
    assign addr_lo   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef ST_SPLIT_EN
    logic [XLEN-1:0] hi_data_q, hi_data_d;
    logic [NB-1:0]   hi_mask_q, hi_mask_d;

    assign reject = size_illegal(req_funct3, XLEN);
`else
    logic unused_hi_data;

    assign unused_hi_data = ^sh_data[2*XLEN-1:XLEN];
    assign reject         = size_illegal(req_funct3, XLEN) || crosses;
`endif

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef ST_SPLIT_EN
        hi_data_d   = hi_data_q;
        hi_mask_d   = hi_mask_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = ST_LO;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = addr_lo;
                        mem_wdata_d = sh_data[XLEN-1:0];
                        mem_wmask_d = sh_mask[NB-1:0];
`ifdef ST_SPLIT_EN
                        hi_data_d   = sh_data[2*XLEN-1:XLEN];
                        hi_mask_d   = sh_mask[2*NB-1:NB];
`endif
                    end
                end
            end
            ST_LO: begin
                if (mem_ready) begin
                    state_d     = ST_IDLE;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
`ifdef ST_SPLIT_EN
                    if (|hi_mask_q) begin
                        // Next word wraps to 0 past the top of the address space.
                        state_d     = ST_HI;
                        mem_valid_d = 1'b1;
                        done_d      = 1'b0;
                        mem_addr_d  = mem_addr_q + ADDR_W'(NB);
                        mem_wdata_d = hi_data_q;
                        mem_wmask_d = hi_mask_q;
                    end
`endif
                end
            end
`ifdef ST_SPLIT_EN
            ST_HI: begin
                if (mem_ready) begin
                    state_d     = ST_IDLE;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef ST_SPLIT_EN
            hi_data_q   <= '0;
            hi_mask_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef ST_SPLIT_EN
            hi_data_q   <= hi_data_d;
            hi_mask_q   <= hi_mask_d;
`endif
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
